// File: rtl/core_pkg.sv
// Shared core types and sizes for the reorder buffer, register file and
// reservation stations.
package core_pkg;

    localparam int ROB_SIZE = 8;                  // power of two
    localparam int IDX_W    = $clog2(ROB_SIZE);
    localparam int TAG_W    = IDX_W + 1;          // extra bit encodes TAG_FREE
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;

    localparam logic [TAG_W-1:0] TAG_FREE = TAG_W'(ROB_SIZE);

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [REG_W-1:0]  dst_reg;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

    // A tag names a real entry only when it is below ROB_SIZE.
    function automatic logic tag_in_range(input logic [TAG_W-1:0] t);
        return t < TAG_W'(ROB_SIZE);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: allocation, CDB capture, operand query and commit port.
interface reorder_buffer_if;
    import core_pkg::*;

    logic              alloc_valid;
    logic [REG_W-1:0]  alloc_reg;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    logic [TAG_W-1:0]  query_tag;
    logic              query_ready;
    logic [DATA_W-1:0] query_data;

    logic              commit_en;
    logic [REG_W-1:0]  commit_reg;
    logic [DATA_W-1:0] commit_data;
    logic [TAG_W-1:0]  commit_tag;

    // Core side: decoder, CDB arbiter, dispatch, register file.
    modport master (
        output alloc_valid, alloc_reg, cdb_valid, cdb_tag, cdb_data, query_tag,
        input  alloc_ready, alloc_tag, query_ready, query_data,
        input  commit_en, commit_reg, commit_data, commit_tag
    );

    // Reorder buffer side.
    modport slave (
        input  alloc_valid, alloc_reg, cdb_valid, cdb_tag, cdb_data, query_tag,
        output alloc_ready, alloc_tag, query_ready, query_data,
        output commit_en, commit_reg, commit_data, commit_tag
    );

endinterface

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy tracking for the reorder buffer. Full and empty come
// from the occupancy count only; the pointers simply wrap.
module rob_ptr_ctrl
    import core_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             alloc_req_i,
    input  logic             commit_i,
    output logic             alloc_fire_o,
    output logic             alloc_ready_o,
    output logic [IDX_W-1:0] head_o,
    output logic [IDX_W-1:0] tail_o
);

    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [TAG_W-1:0] count_q, count_d;

    // Registered count only: a slot freed by commit is offered next cycle.
    assign alloc_ready_o = (count_q != TAG_W'(ROB_SIZE));
    assign alloc_fire_o  = alloc_req_i && alloc_ready_o && !flush_i;
    assign head_o        = head_q;
    assign tail_o        = tail_q;

    // Next pointer/count; flush returns everything to the empty state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_fire_o) tail_d = tail_q + 1'b1;
            if (commit_i)     head_d = head_q + 1'b1;
            case ({alloc_fire_o, commit_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates entries per decoded instruction, captures
// CDB results and retires them in program order through a registered commit
// port. Optional macro ROB_FLUSH_EN adds a flush input that empties the buffer.
module reorder_buffer
    import core_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef ROB_FLUSH_EN
    input  logic flush,
`endif
    reorder_buffer_if.slave bus
);

    rob_entry_t rob_q [ROB_SIZE];
    rob_entry_t rob_d [ROB_SIZE];

    logic              commit_en_q,   commit_en_d;
    logic [REG_W-1:0]  commit_reg_q,  commit_reg_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;
    logic [TAG_W-1:0]  commit_tag_q,  commit_tag_d;

    logic             flush_w;
    logic             alloc_fire;
    logic             commit_fire;
    logic             cdb_hit;
    logic [IDX_W-1:0] head, tail, cdb_idx, q_idx;
    rob_entry_t       head_ent, cdb_ent, q_ent;

`ifdef ROB_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign head_ent    = rob_q[head];
    assign commit_fire = !flush_w && head_ent.busy && head_ent.ready;

    // A CDB tag landing on the entry being allocated misses naturally: a free
    // tail slot is never busy, so allocation wins without extra logic.
    assign cdb_idx = bus.cdb_tag[IDX_W-1:0];
    assign cdb_ent = rob_q[cdb_idx];
    assign cdb_hit = bus.cdb_valid && !flush_w && tag_in_range(bus.cdb_tag)
                     && cdb_ent.busy && !cdb_ent.ready;

    rob_ptr_ctrl u_ptr (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_w),
        .alloc_req_i   (bus.alloc_valid),
        .commit_i      (commit_fire),
        .alloc_fire_o  (alloc_fire),
        .alloc_ready_o (bus.alloc_ready),
        .head_o        (head),
        .tail_o        (tail)
    );

    assign bus.alloc_tag = {1'b0, tail};

    // Entry and commit-port next state: commit the head, capture CDB, allocate.
    always_comb begin
        rob_d         = rob_q;
        commit_en_d   = 1'b0;
        commit_reg_d  = commit_reg_q;
        commit_data_d = commit_data_q;
        commit_tag_d  = commit_tag_q;
        if (flush_w) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                rob_d[i].busy  = 1'b0;
                rob_d[i].ready = 1'b0;
            end
        end else begin
            if (commit_fire) begin
                commit_en_d         = 1'b1;
                commit_reg_d        = head_ent.dst_reg;
                commit_data_d       = head_ent.data;
                commit_tag_d        = {1'b0, head};
                rob_d[head].busy    = 1'b0;
                rob_d[head].ready   = 1'b0;
            end
            if (cdb_hit) begin
                rob_d[cdb_idx].ready = 1'b1;
                rob_d[cdb_idx].data  = bus.cdb_data;
            end
            if (alloc_fire) begin
                rob_d[tail].busy    = 1'b1;
                rob_d[tail].ready   = 1'b0;
                rob_d[tail].dst_reg = bus.alloc_reg;
            end
        end
    end

    // Entry storage and commit port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) rob_q[i] <= '0;
            commit_en_q   <= 1'b0;
            commit_reg_q  <= '0;
            commit_data_q <= '0;
            commit_tag_q  <= TAG_FREE;
        end else begin
            rob_q         <= rob_d;
            commit_en_q   <= commit_en_d;
            commit_reg_q  <= commit_reg_d;
            commit_data_q <= commit_data_d;
            commit_tag_q  <= commit_tag_d;
        end
    end

    assign bus.commit_en   = commit_en_q;
    assign bus.commit_reg  = commit_reg_q;
    assign bus.commit_data = commit_data_q;
    assign bus.commit_tag  = commit_tag_q;

    // Operand lookup: stored value, else same-cycle CDB bypass.
    assign q_idx = bus.query_tag[IDX_W-1:0];
    assign q_ent = rob_q[q_idx];
    always_comb begin
        bus.query_ready = 1'b0;
        bus.query_data  = '0;
        if (tag_in_range(bus.query_tag) && q_ent.busy) begin
            if (q_ent.ready) begin
                bus.query_ready = 1'b1;
                bus.query_data  = q_ent.data;
            end else if (bus.cdb_valid && bus.cdb_tag == bus.query_tag) begin
                bus.query_ready = 1'b1;
                bus.query_data  = bus.cdb_data;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a program-order queue model checked
// every cycle, plus literal expectations at key points.
module tb_reorder_buffer;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fl  = 1'b0;

    reorder_buffer_if rif();

    reorder_buffer dut (
        .clk  (clk),
        .rst  (rst),
`ifdef ROB_FLUSH_EN
        .flush(fl),
`endif
        .bus  (rif.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: in-flight instructions in program order.
    typedef struct {
        int          tag;
        int          rg;
        bit          rdy;
        logic [31:0] data;
    } inst_t;

    inst_t       mq[$];
    int          m_next = 0;
    bit          m_en   = 1'b0;
    int          m_reg  = 0;
    logic [31:0] m_data = '0;
    int          m_tag  = ROB_SIZE;

    always @(posedge clk or posedge rst) begin
        bit full;
        bit do_commit;
        if (rst) begin
            mq.delete();
            m_next = 0; m_en = 0; m_reg = 0; m_data = '0; m_tag = ROB_SIZE;
        end else if (fl) begin
            mq.delete();
            m_next = 0; m_en = 0;
        end else begin
            full      = (mq.size() == ROB_SIZE);
            do_commit = (mq.size() > 0) && mq[0].rdy;
            if (rif.cdb_valid)
                foreach (mq[k])
                    if (mq[k].tag == int'(rif.cdb_tag) && !mq[k].rdy) begin
                        mq[k].rdy  = 1'b1;
                        mq[k].data = rif.cdb_data;
                    end
            if (do_commit) begin
                m_en = 1; m_reg = mq[0].rg; m_data = mq[0].data; m_tag = mq[0].tag;
                void'(mq.pop_front());
            end else begin
                m_en = 0;
            end
            if (rif.alloc_valid && !full) begin
                mq.push_back('{m_next, int'(rif.alloc_reg), 1'b0, 32'h0});
                m_next = (m_next + 1) % ROB_SIZE;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit          qr;
        logic [31:0] qd;
        qr = 0; qd = '0;
        foreach (mq[k])
            if (mq[k].tag == int'(rif.query_tag)) begin
                if (mq[k].rdy) begin
                    qr = 1; qd = mq[k].data;
                end else if (rif.cdb_valid && rif.cdb_tag == rif.query_tag) begin
                    qr = 1; qd = rif.cdb_data;
                end
            end
        chk("m_alloc_ready", 64'(rif.alloc_ready), 64'(mq.size() < ROB_SIZE));
        chk("m_alloc_tag",   64'(rif.alloc_tag),   64'(m_next));
        chk("m_commit_en",   64'(rif.commit_en),   64'(m_en));
        chk("m_commit_reg",  64'(rif.commit_reg),  64'(m_reg));
        chk("m_commit_data", 64'(rif.commit_data), 64'(m_data));
        chk("m_commit_tag",  64'(rif.commit_tag),  64'(m_tag));
        chk("m_query_ready", 64'(rif.query_ready), 64'(qr));
        chk("m_query_data",  64'(rif.query_data),  64'(qd));
    end

    task automatic drive(input bit av, input int rg, input bit cv, input int ct,
                         input logic [31:0] cd, input int qt);
        rif.alloc_valid = av;
        rif.alloc_reg   = REG_W'(rg);
        rif.cdb_valid   = cv;
        rif.cdb_tag     = TAG_W'(ct);
        rif.cdb_data    = cd;
        rif.query_tag   = TAG_W'(qt);
    endtask

    // Hold inputs across one rising edge; returns 2 time units after it.
    task automatic step(input bit av, input int rg, input bit cv, input int ct,
                        input logic [31:0] cd, input int qt);
        drive(av, rg, cv, ct, cd, qt);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 32'h0, ROB_SIZE);
    endtask

    initial begin
        drive(0, 0, 0, 0, 32'h0, ROB_SIZE);
        repeat (2) @(posedge clk);
        #2;
        chk("rst_alloc_ready", 64'(rif.alloc_ready), 64'd1);
        chk("rst_alloc_tag",   64'(rif.alloc_tag),   64'd0);
        chk("rst_commit_en",   64'(rif.commit_en),   64'd0);
        chk("rst_commit_tag",  64'(rif.commit_tag),  64'd8);
        chk("rst_commit_data", 64'(rif.commit_data), 64'd0);
        rst = 1'b0;

        // r3, r5, r7 get tags 0, 1, 2
        chk("tag_r3", 64'(rif.alloc_tag), 64'd0); step(1, 3, 0, 0, 0, ROB_SIZE);
        chk("tag_r5", 64'(rif.alloc_tag), 64'd1); step(1, 5, 0, 0, 0, ROB_SIZE);
        chk("tag_r7", 64'(rif.alloc_tag), 64'd2); step(1, 7, 0, 0, 0, ROB_SIZE);
        chk("tag_next", 64'(rif.alloc_tag), 64'd3);

        // tag1 ready, duplicate to tag1 ignored, then tag0 ready
        step(0, 0, 1, 1, 32'h11, ROB_SIZE);
        step(0, 0, 1, 1, 32'h99, ROB_SIZE);
        step(0, 0, 1, 0, 32'h22, ROB_SIZE);
        chk("no_commit_yet", 64'(rif.commit_en), 64'd0);
        idle();
        chk("c0_en",   64'(rif.commit_en),   64'd1);
        chk("c0_reg",  64'(rif.commit_reg),  64'd3);
        chk("c0_data", 64'(rif.commit_data), 64'h22);
        chk("c0_tag",  64'(rif.commit_tag),  64'd0);
        idle();
        chk("c1_en",   64'(rif.commit_en),   64'd1);
        chk("c1_reg",  64'(rif.commit_reg),  64'd5);
        chk("c1_data", 64'(rif.commit_data), 64'h11);
        chk("c1_tag",  64'(rif.commit_tag),  64'd1);
        idle();
        chk("r7_waits",  64'(rif.commit_en),  64'd0);
        chk("tag_holds", 64'(rif.commit_tag), 64'd1);

        // bypass query on tag 2, then stored value, then commit r7
        drive(0, 0, 1, 2, 32'h55, 2);
        #1;
        chk("byp_ready", 64'(rif.query_ready), 64'd1);
        chk("byp_data",  64'(rif.query_data),  64'h55);
        @(posedge clk); #2;
        drive(0, 0, 0, 0, 32'h0, 2);
        #1;
        chk("stored_data", 64'(rif.query_data), 64'h55);
        @(posedge clk); #2;
        chk("c2_reg", 64'(rif.commit_reg), 64'd7);
        drive(0, 0, 0, 0, 32'h0, ROB_SIZE);
        #1;
        chk("free_query", 64'(rif.query_ready), 64'd0);

        // TAG_FREE and non-busy CDB do nothing
        step(0, 0, 1, ROB_SIZE, 32'hAA, ROB_SIZE);
        step(0, 0, 1, 5, 32'hBB, ROB_SIZE);
        idle();
        chk("ign_commit_en", 64'(rif.commit_en), 64'd0);
        chk("ign_alloc_tag", 64'(rif.alloc_tag), 64'd3);

        // reset in the middle of activity
        step(1, 9, 0, 0, 0, ROB_SIZE);
        rst = 1'b1;
        #1;
        chk("midrst_tag", 64'(rif.alloc_tag), 64'd0);
        idle();
        rst = 1'b0;

        // fill all 8 entries (r0 included), 9th ignored
        for (int i = 0; i < ROB_SIZE; i++) step(1, i, 0, 0, 0, ROB_SIZE);
        chk("full_ready", 64'(rif.alloc_ready), 64'd0);
        step(1, 9, 0, 0, 0, ROB_SIZE);
        chk("full_tag", 64'(rif.alloc_tag), 64'd0);
        step(0, 0, 1, 0, 32'hDEAD, ROB_SIZE);
        chk("full_noc", 64'(rif.commit_en), 64'd0);
        idle();
        chk("dead_en",    64'(rif.commit_en),   64'd1);
        chk("dead_data",  64'(rif.commit_data), 64'hDEAD);
        chk("dead_tag",   64'(rif.commit_tag),  64'd0);
        chk("dead_reg",   64'(rif.commit_reg),  64'd0);
        chk("freed_rdy",  64'(rif.alloc_ready), 64'd1);
        chk("wrap_tag",   64'(rif.alloc_tag),   64'd0);
        step(1, 12, 0, 0, 0, ROB_SIZE);
        chk("refull_rdy", 64'(rif.alloc_ready), 64'd0);
        chk("refull_tag", 64'(rif.alloc_tag),   64'd1);

`ifdef ROB_FLUSH_EN
        rst = 1'b1;
        idle();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, i + 1, 0, 0, 0, ROB_SIZE);
        step(0, 0, 1, 1, 32'h101, ROB_SIZE);
        step(0, 0, 1, 2, 32'h202, ROB_SIZE);
        fl = 1'b1;
        step(1, 6, 1, 0, 32'h303, ROB_SIZE);
        fl = 1'b0;
        chk("fl_ready", 64'(rif.alloc_ready), 64'd1);
        chk("fl_tag",   64'(rif.alloc_tag),   64'd0);
        chk("fl_en",    64'(rif.commit_en),   64'd0);
        step(0, 0, 1, 1, 32'h404, ROB_SIZE);
        idle();
        chk("fl_quiet", 64'(rif.commit_en), 64'd0);
`endif

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
